// File: rtl/mem_exec_unit_pkg.sv
// Shared types and constants for the memory execution unit slice.
package mem_exec_unit_pkg;

  localparam int unsigned OPC_W     = 3;
  localparam int unsigned VAL_W     = 3;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned ROB_W     = 2;
  localparam int unsigned MEM_WORDS = 4;

  localparam logic [OPC_W-1:0] OP_LD  = 3'b101;
  localparam logic [OPC_W-1:0] OP_STR = 3'b110;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [VAL_W-1:0]  val;
    logic [ADDR_W-1:0] addr;
    logic [ROB_W-1:0]  rob_idx;
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    BCAST  = 2'd2
  } lsu_state_t;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_LD) || (opc == OP_STR);
  endfunction

endpackage

// File: rtl/mem_exec_unit_if.sv
// Issue-side and CDB-side signals between reservation stations and the memory unit.
interface mem_exec_unit_if;
  import mem_exec_unit_pkg::*;

  logic              issue_valid;
  logic [OPC_W-1:0]  issue_opcode;
  logic [VAL_W-1:0]  issue_val;
  logic [ADDR_W-1:0] issue_addr;
  logic [ROB_W-1:0]  issue_rob_idx;
  logic              cdb_grant;
  logic              cdb_req;
  logic              cdb_en;
  logic [ROB_W-1:0]  cdb_rob_idx;
  logic [VAL_W-1:0]  cdb_val;

  modport master (
    output issue_valid, issue_opcode, issue_val, issue_addr, issue_rob_idx, cdb_grant,
    input  cdb_req, cdb_en, cdb_rob_idx, cdb_val
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_val, issue_addr, issue_rob_idx, cdb_grant,
    output cdb_req, cdb_en, cdb_rob_idx, cdb_val
  );

endinterface

// File: rtl/mem_exec_queue.sv
// In-order input FIFO of memory ops; flush empties it, overflow is sticky until reset.
module mem_exec_queue
  import mem_exec_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push,
  input  logic    pop,
  input  mem_op_t wr_data,
  output mem_op_t rd_data,
  output logic    full,
  output logic    empty,
  output logic    overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mem_op_t            buf_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign rd_data = buf_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      buf_q[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_exec_unit.sv
// Memory execution unit: queues issued LD/STR ops, runs them in order against a
// private 4-word memory and broadcasts each result on the CDB.
module mem_exec_unit
  import mem_exec_unit_pkg::*;
#(
  parameter int unsigned QDEPTH      = 2,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  mem_exec_unit_if.slave        bus,
  output logic                  lsu_full,
  output logic                  lsu_idle,
  output logic                  illegal_op,
  output logic                  overflow
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  mem_op_t           issue_op;
  mem_op_t           head_op;
  mem_op_t           op_q;
  lsu_state_t        state_q;
  lsu_state_t        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [VAL_W-1:0]  res_q;
  logic [VAL_W-1:0]  mem_q [MEM_WORDS];
  logic              legal;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              access_done;

  assign issue_op = '{opcode:  bus.issue_opcode,
                      val:     bus.issue_val,
                      addr:    bus.issue_addr,
                      rob_idx: bus.issue_rob_idx};
  assign legal    = is_mem_op(bus.issue_opcode);
  assign push     = bus.issue_valid && legal && !flush;

  mem_exec_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .wr_data  (issue_op),
    .rd_data  (head_op),
    .full     (lsu_full),
    .empty    (q_empty),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!q_empty)       state_d = ACCESS;
        ACCESS:  if (cnt_q == '0)    state_d = BCAST;
        BCAST:   if (bus.cdb_grant)  state_d = IDLE;
        default:                     state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pop         = 1'b0;
    access_done = 1'b0;
    bus.cdb_req = 1'b0;
    bus.cdb_en  = 1'b0;
    lsu_idle    = 1'b0;
    unique case (state_q)
      IDLE: begin
        pop      = !q_empty && !flush;
        lsu_idle = q_empty;
      end
      ACCESS:  access_done = (cnt_q == '0) && !flush;
      BCAST: begin
        bus.cdb_req = 1'b1;
        bus.cdb_en  = bus.cdb_grant;
      end
      default: ;
    endcase
  end

  assign bus.cdb_rob_idx = op_q.rob_idx;
  assign bus.cdb_val     = res_q;

  // Op register, latency counter, result register and data memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      illegal_op <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      illegal_op <= bus.issue_valid && !legal && !flush;
      if (pop) begin
        op_q  <= head_op;
        cnt_q <= CNT_W'(MEM_LATENCY - 1);
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (access_done) begin
        if (op_q.opcode == OP_STR) begin
          mem_q[op_q.addr] <= op_q.val;
          res_q            <= op_q.val;
        end else begin
          res_q <= mem_q[op_q.addr];
        end
      end
    end
  end

endmodule
